// File: rtl/i_tx_if.sv
// Transmit-chain bus: rate enables, symbol input and sample output.
// The module instance uses the slave modport; the stimulus side uses master.
interface i_tx_if;
    logic               sym_clk;
    logic               sam_clk;
    logic               clk_int;
    logic signed [17:0] data_in;
    logic signed [17:0] data_out;

    modport master (output sym_clk, sam_clk, clk_int, data_in, input data_out);
    modport slave  (input sym_clk, sam_clk, clk_int, data_in, output data_out);
endinterface

// File: rtl/i_tx.sv
// x16 interpolating transmit chain: TXF (x4 shaping) -> HB1 (x2) -> HB2 (x2).
// Optional macro I_TX_SAT_EN saturates the final output instead of wrapping it.
module i_tx (
    input  logic   clk,
    input  logic   reset,
    i_tx_if.slave  bus
);
    localparam int AW   = 24;
    localparam int TAPS = 7;

    typedef logic signed [AW-1:0] acc_t;

    // Half-band kernel [-1,0,9,16,9,0,-1]; zero taps are not passed in.
    function automatic acc_t hb_sum(acc_t w0, acc_t w2, acc_t w3, acc_t w4, acc_t w6);
        return -w0 + ((w2 <<< 3) + w2) + (w3 <<< 4) + ((w4 <<< 3) + w4) - w6;
    endfunction

    // Stored taps hold the six previous samples; the incoming sample is tap 0.
    acc_t txf_q [TAPS-1];
    acc_t hb1_q [TAPS-1];
    acc_t hb2_q [TAPS-1];
    acc_t tx_y_q, tx_y_d;
    acc_t hb1_y_q, hb1_y_d;
    acc_t txf_in, hb1_in, hb2_in;
    acc_t txf_sum, hb2_res;
    logic signed [17:0] data_out_q, data_out_d;

    always_comb begin
        txf_in  = bus.sym_clk ? acc_t'(bus.data_in) : '0;
        hb1_in  = bus.sam_clk ? tx_y_q : '0;
        hb2_in  = bus.clk_int ? hb1_y_q : '0;

        // Shaping kernel [1,2,3,4,3,2,1].
        txf_sum = txf_in + (txf_q[0] <<< 1) + ((txf_q[1] <<< 1) + txf_q[1])
                + (txf_q[2] <<< 2) + ((txf_q[3] <<< 1) + txf_q[3])
                + (txf_q[4] <<< 1) + txf_q[5];
        tx_y_d  = txf_sum >>> 2;
        hb1_y_d = hb_sum(hb1_in, hb1_q[1], hb1_q[2], hb1_q[3], hb1_q[5]) >>> 4;
        hb2_res = hb_sum(hb2_in, hb2_q[1], hb2_q[2], hb2_q[3], hb2_q[5]) >>> 4;

`ifdef I_TX_SAT_EN
        if (hb2_res > 24'sd131071)
            data_out_d = 18'sh1FFFF;
        else if (hb2_res < -24'sd131072)
            data_out_d = 18'sh20000;
        else
            data_out_d = hb2_res[17:0];
`else
        data_out_d = hb2_res[17:0];
`endif
    end

`ifndef I_TX_SAT_EN
    logic unused_hi;
    assign unused_hi = ^hb2_res[AW-1:18];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < TAPS-1; k++) begin
                txf_q[k] <= '0;
                hb1_q[k] <= '0;
                hb2_q[k] <= '0;
            end
            tx_y_q     <= '0;
            hb1_y_q    <= '0;
            data_out_q <= '0;
        end else begin
            if (bus.sam_clk) begin
                txf_q[0] <= txf_in;
                for (int k = 1; k < TAPS-1; k++) txf_q[k] <= txf_q[k-1];
                tx_y_q <= tx_y_d;
            end
            if (bus.clk_int) begin
                hb1_q[0] <= hb1_in;
                for (int k = 1; k < TAPS-1; k++) hb1_q[k] <= hb1_q[k-1];
                hb1_y_q <= hb1_y_d;
            end
            // HB2 runs at full clk rate, so its line always shifts.
            hb2_q[0] <= hb2_in;
            for (int k = 1; k < TAPS-1; k++) hb2_q[k] <= hb2_q[k-1];
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
endmodule

// File: doc/i_tx.md
I_TX -- requirements
Module: i_tx

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single system clock, fastest rate; all registers update on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 The module SHALL have port sym_clk, input, 1 bit: one-clk-wide symbol-rate enable, once every 16 clk.
REQ-004 The module SHALL have port sam_clk, input, 1 bit: one-clk-wide sample-rate enable, once every 4 clk.
REQ-005 The module SHALL have port clk_int, input, 1 bit: one-clk-wide intermediate-rate enable, once every 2 clk.
REQ-006 The module SHALL have port data_in, input, signed 18 bits: mapped symbol value, sampled only on sym_clk.
REQ-007 The module SHALL have port data_out, output, signed 18 bits: interpolated transmit sample, one per clk.
REQ-008 The module SHALL assume every sym_clk pulse coincides with a sam_clk pulse, and every sam_clk pulse coincides with a clk_int pulse; behaviour for misaligned enables is unspecified.

Function
REQ-009 The module SHALL form a 3-stage interpolating transmit chain: upsample x4 plus shaping filter (TXF), then x2 plus half-band (HB1), then x2 plus half-band (HB2), for a total of x16.
REQ-010 TXF SHALL be a 7-tap delay line that shifts on sam_clk only: it shifts in data_in when sym_clk is also high, else 0.
REQ-011 TXF coefficients SHALL be [1,2,3,4,3,2,1]; the sum SHALL be arithmetic-shifted right by 2 (floor) and registered into tx_y on the same sam_clk.
REQ-012 HB1 SHALL be a 7-tap delay line that shifts on clk_int only: it shifts in tx_y when sam_clk is also high, else 0.
REQ-013 HB1 coefficients SHALL be [-1,0,9,16,9,0,-1]; the sum SHALL be arithmetic-shifted right by 4 (floor) and registered into hb1_y on the same clk_int.
REQ-014 HB2 SHALL be a 7-tap delay line that shifts every clk: it shifts in hb1_y when clk_int is high, else 0.
REQ-015 HB2 SHALL use the same coefficients and shift as HB1, and its result SHALL be registered into data_out every clk.
REQ-016 Coefficient products SHALL be implemented as shifts and adds with no multipliers; accumulators SHALL be signed 24 bits; no stage SHALL overflow internally.
REQ-017 Each polyphase branch of every stage SHALL have unity gain, so a constant symbol value V SHALL settle to data_out = V exactly for |V| < 2^17.
REQ-018 Per-stage register latency SHALL be 1 enable period of that stage: TXF output registered on sam_clk, HB1 on clk_int, HB2 on clk.
REQ-019 While no enable is asserted, the TXF and HB1 delay lines and registers SHALL hold their values.
REQ-020 The HB2 delay line SHALL always shift, because HB2 runs at clk rate.
REQ-021 data_in SHALL be ignored on any clk where sym_clk is low.

Reset
REQ-022 While reset = 0 at a clk edge, all delay-line taps, tx_y, hb1_y and data_out SHALL load 0, regardless of the enables.
REQ-023 An assertion of reset in mid-stream SHALL discard all in-flight samples; the first output after release SHALL depend only on symbols accepted after release.
REQ-024 Once reset is released, the first symbol accepted SHALL be the one on the first sym_clk with reset = 1.

Configuration
REQ-025 When macro I_TX_SAT_EN is defined, the HB2 result SHALL saturate to [-131072, 131071] before being registered into data_out.
REQ-026 When I_TX_SAT_EN is undefined, data_out SHALL be the low 18 bits of the HB2 result (two's-complement wrap).
REQ-027 With I_TX_SAT_EN undefined, all other behaviour SHALL be identical.

Verification
REQ-028 Reset: hold reset = 0 for 20 clk with random data_in and enables toggling -> data_out = 0 on every cycle; first symbol 16384 after release -> nonzero data_out only after release.
REQ-029 Impulse: one symbol 16384, then 0s -> tx_y sequence on successive sam_clk = 4096, 8192, 12288, 16384, 12288, 8192, 4096, 0; data_out matches the bit-exact model.
REQ-030 DC: constant symbol -20000 for 40 symbols -> data_out settles to exactly -20000 and stays there.
REQ-031 Mid-stream reset: drive random symbols, pulse reset = 0 for one clk between sam_clk pulses -> the next data_out = 0 and the chain restarts cleanly.
REQ-032 Full-scale: 2000 random symbols from {-131072, 131071} -> with I_TX_SAT_EN, data_out equals the unsaturated model clamped to range; without it, data_out equals the model modulo 2^18.
